// File: rtl/telemetry_frame_tx_if.sv
// telemetry_frame_tx_if: valid/ready byte stream from the frame serializer to the UART transmitter
interface telemetry_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/telemetry_frame_tx.sv
// telemetry_frame_tx: snapshots NUM_CH channel words and streams them as a header/data/checksum byte frame
module telemetry_frame_tx #(
  parameter int         NUM_CH      = 4,
  parameter int         CH_WIDTH    = 8,
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter bit         CHECKSUM_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       trigger_i,
  input  logic                       auto_mode_i,
  input  logic [NUM_CH*CH_WIDTH-1:0] ch_data_i,
  telemetry_frame_tx_if.master       tx,
  output logic                       busy_o,
  output logic                       frame_done_o,
  output logic                       overrun_o
);
  localparam int BPC = CH_WIDTH / 8;
  localparam int B   = NUM_CH * BPC;
  localparam int IW  = $clog2(B + 2);
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CSUM} state_t;
  state_t                     state_q;
  logic [NUM_CH*CH_WIDTH-1:0] snap_q;
  logic [B*8-1:0]             ord;
  logic [IW-1:0]              idx_q;
  logic [7:0]                 csum_q, tx_data_q;
  logic                       tx_valid_q, frame_done_q, overrun_q, xfer, start;
  // ord holds the snapshot in transmit order: channel 0 first, MSB first within a channel
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar m = 0; m < BPC; m++) begin : g_byte
      assign ord[(c*BPC+m)*8 +: 8] = snap_q[c*CH_WIDTH + (BPC-1-m)*8 +: 8];
    end
  end
  assign xfer         = tx_valid_q & tx.tx_ready;
  assign start        = trigger_i | (auto_mode_i & frame_done_q);
  assign tx.tx_data   = tx_data_q;
  assign tx.tx_valid  = tx_valid_q;
  assign busy_o       = state_q != S_IDLE;
  assign frame_done_o = frame_done_q;
  assign overrun_o    = overrun_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      snap_q       <= '0;
      idx_q        <= '0;
      csum_q       <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      overrun_q    <= trigger_i & (state_q != S_IDLE);
      case (state_q)
        S_IDLE: if (start) begin
          state_q    <= S_HDR;
          snap_q     <= ch_data_i;
          idx_q      <= '0;
          csum_q     <= '0;
          tx_data_q  <= HEADER;
          tx_valid_q <= 1'b1;
        end
        S_HDR: if (xfer) begin
          state_q   <= S_DATA;
          csum_q    <= csum_q ^ tx_data_q;
          tx_data_q <= ord[7:0];
        end
        S_DATA: if (xfer) begin
          csum_q <= csum_q ^ tx_data_q;
          if (idx_q == IW'(B - 1)) begin
            if (CHECKSUM_EN) begin
              state_q   <= S_CSUM;
              tx_data_q <= csum_q ^ tx_data_q;
            end else begin
              state_q      <= S_IDLE;
              tx_data_q    <= '0;
              tx_valid_q   <= 1'b0;
              frame_done_q <= 1'b1;
            end
          end else begin
            idx_q     <= idx_q + IW'(1);
            tx_data_q <= ord[8*(int'(idx_q)+1) +: 8];
          end
        end
        S_CSUM: if (xfer) begin
          state_q      <= S_IDLE;
          tx_data_q    <= '0;
          tx_valid_q   <= 1'b0;
          frame_done_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_telemetry_frame_tx.sv
// tb_telemetry_frame_tx: directed and randomized frames checked against a byte-list model of the frame format
module tb_telemetry_frame_tx;
  typedef logic [7:0] bq_t[$];
  logic        clk = 1'b0;
  logic        rst, trig, auto_m, busy, fd, ov;
  logic [31:0] ch;
  logic        trig2, busy2, fd2, ov2;
  logic [31:0] ch2;
  int          n_assert = 0;
  int          n_fail = 0;
  telemetry_frame_tx_if tif ();
  telemetry_frame_tx_if tif2 ();
  telemetry_frame_tx dut (
    .clk(clk), .rst(rst), .trigger_i(trig), .auto_mode_i(auto_m), .ch_data_i(ch),
    .tx(tif.master), .busy_o(busy), .frame_done_o(fd), .overrun_o(ov)
  );
  telemetry_frame_tx #(.NUM_CH(2), .CH_WIDTH(16), .CHECKSUM_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .trigger_i(trig2), .auto_mode_i(1'b0), .ch_data_i(ch2),
    .tx(tif2.master), .busy_o(busy2), .frame_done_o(fd2), .overrun_o(ov2)
  );
  always #5 clk = ~clk;
  function automatic bq_t build(input logic [31:0] d, input int nch, input int cw, input bit cs);
    bq_t q;
    logic [7:0] x;
    logic [31:0] w;
    q = {8'hA5};
    x = 8'hA5;
    for (int k = 0; k < nch; k++)
      for (int m = 0; m < cw / 8; m++) begin
        w = d >> (k * cw + (cw / 8 - 1 - m) * 8);
        q.push_back(w[7:0]);
        x = x ^ w[7:0];
      end
    if (cs) q.push_back(x);
    return q;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start1(input logic [31:0] d);
    ch = d;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("lat_valid", tif.tx_valid, 1);
    chk("lat_header", tif.tx_data, 8'hA5);
    chk("lat_busy", busy, 1);
  endtask
  // Called at the negedge where the header is first valid; returns at the frame_done negedge
  task automatic check_frame(input bq_t e, input int rmode, input int trig_at);
    int k = 0;
    int cyc = 0;
    logic hold = 1'b0;
    logic [7:0] held = '0;
    logic ov_exp = 1'b0;
    logic r;
    while (k < e.size() && cyc < 400) begin
      chk("overrun", ov, ov_exp);
      chk("busy", busy, 1);
      chk("valid", tif.tx_valid, 1);
      chk("done_low", fd, 0);
      if (hold) chk("hold_data", tif.tx_data, held);
      r = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      tif.tx_ready = r;
      trig = (cyc == trig_at);
      ov_exp = trig & busy;
      if (r) begin
        chk("byte", tif.tx_data, e[k]);
        k++;
        hold = 1'b0;
      end else begin
        hold = 1'b1;
        held = tif.tx_data;
      end
      cyc++;
      @(negedge clk);
    end
    trig = 1'b0;
    chk("frame_len", k, e.size());
    chk("done_pulse", fd, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", tif.tx_valid, 0);
    chk("done_ov", ov, ov_exp);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] d;
    bq_t e;
    rst = 1'b1; trig = 1'b0; auto_m = 1'b0; ch = '0; trig2 = 1'b0; ch2 = '0;
    tif.tx_ready = 1'b0;
    tif2.tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", tif.tx_valid, 0);
    chk("rst_data", tif.tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", fd, 0);
    chk("rst_ov", ov, 0);
    chk("rst_valid2", tif2.tx_valid, 0);
    chk("rst_busy2", busy2, 0);
    rst = 1'b0;
    @(negedge clk);
    start1(32'h44332211);
    check_frame(build(32'h44332211, 4, 8, 1), 0, -1);
    @(negedge clk);
    start1(32'h44332211);
    check_frame(build(32'h44332211, 4, 8, 1), 1, -1);
    @(negedge clk);
    start1(32'h44332211);
    ch = 32'hFFFFFFFF;
    check_frame(build(32'h44332211, 4, 8, 1), 0, 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      d = $urandom;
      start1(d);
      ch = $urandom;
      check_frame(build(d, 4, 8, 1), 2, int'($urandom_range(0, 9)));
    end
    @(negedge clk);
    auto_m = 1'b1;
    d = $urandom;
    start1(d);
    for (int f = 0; f < 3; f++) begin
      check_frame(build(d, 4, 8, 1), f == 1 ? 2 : 0, -1);
      d = $urandom;
      ch = d;
      trig = (f == 1);
      @(negedge clk);
      trig = 1'b0;
      chk("auto_gap_valid", tif.tx_valid, 1);
      chk("auto_gap_header", tif.tx_data, 8'hA5);
      chk("auto_absorb_ov", ov, 0);
      ch = $urandom;
    end
    auto_m = 1'b0;
    check_frame(build(d, 4, 8, 1), 0, -1);
    @(negedge clk);
    chk("auto_stop_valid", tif.tx_valid, 0);
    chk("auto_stop_busy", busy, 0);
    d = $urandom;
    e = build(d, 4, 8, 1);
    start1(d);
    tif.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_byte", tif.tx_data, e[3]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", tif.tx_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", tif.tx_data, 0);
    @(negedge clk);
    chk("post_rst_idle", tif.tx_valid, 0);
    d = $urandom;
    start1(d);
    check_frame(build(d, 4, 8, 1), 2, -1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      d = (i == 0) ? 32'hBEEF_1234 : $urandom;
      e = build(d, 2, 16, 0);
      ch2 = d;
      trig2 = 1'b1;
      @(negedge clk);
      trig2 = 1'b0;
      ch2 = $urandom;
      foreach (e[j]) begin
        chk("d2_valid", tif2.tx_valid, 1);
        chk("d2_byte", tif2.tx_data, e[j]);
        @(negedge clk);
      end
      chk("d2_done", fd2, 1);
      chk("d2_busy", busy2, 0);
      chk("d2_valid_end", tif2.tx_valid, 0);
      chk("d2_ov", ov2, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
